// File: rtl/freq_meas_pkg.sv
// Shared types and defaults for the clock period meter.
`timescale 1ns/1ps
package freq_meas_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [0:0] {
        SEEK = 1'b0,
        MEAS = 1'b1
    } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronises an asynchronous input into the clk domain and emits
// registered single-cycle rise/fall strobes.
`timescale 1ns/1ps
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   dly_r;
    logic                   sync_s;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain, one-cycle delay copy and registered edge strobes.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_r <= '0;
            dly_r  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
            dly_r  <= sync_s;
            rise   <= sync_s & ~dly_r;
            fall   <= ~sync_s & dly_r;
        end
    end

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous signal in clk cycles,
// with a sticky timeout flag when no edge arrives within the counter range.
`timescale 1ns/1ps
module clk_period_meter
    import freq_meas_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             is_odd,
    output logic             meas_valid,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] hi_cnt_r;
    logic             rise_s;
    logic             fall_s;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_det (
        .clk   (clk),
        .clr   (clr),
        .sig_in(sig_in),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // Measurement FSM: counts cycles between rises, latches the fall point,
    // and a rise coinciding with the count limit still counts as a measurement.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r    <= SEEK;
            cnt_r      <= '0;
            hi_cnt_r   <= '0;
            period     <= '0;
            high_time  <= '0;
            is_odd     <= 1'b0;
            meas_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state_r)
                SEEK: begin
                    if (rise_s) begin
                        cnt_r    <= CNT_ONE;
                        hi_cnt_r <= '0;
                        state_r  <= MEAS;
                    end
                end
                MEAS: begin
                    if (rise_s) begin
                        period     <= cnt_r;
                        high_time  <= hi_cnt_r;
                        is_odd     <= cnt_r[0];
                        meas_valid <= 1'b1;
                        ovf        <= 1'b0;
                        cnt_r      <= CNT_ONE;
                        hi_cnt_r   <= '0;
                    end else if (cnt_r == CNT_MAX) begin
                        ovf     <= 1'b1;
                        state_r <= SEEK;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                        if (fall_s) begin
                            hi_cnt_r <= cnt_r;
                        end
                    end
                end
                default: begin
                    state_r <= SEEK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: table-driven patterns, directed
// timeout/reset sequences and a randomised-offset run against an edge-timestamp model.
`timescale 1ns/1ps
module tb_clk_period_meter;
    import freq_meas_pkg::*;

    localparam int CW  = 8;
    localparam int SS  = 2;
    localparam int LIM = 255;
    localparam int LAT = 4;

    logic          clk    = 1'b0;
    logic          clr    = 1'b0;
    logic          sig_in = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          is_odd;
    logic          meas_valid;
    logic          ovf;

    clk_period_meter #(.CNT_W(CW), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .clr       (clr),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .is_odd    (is_odd),
        .meas_valid(meas_valid),
        .ovf       (ovf)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: timestamps of sampled sig_in edges give expected results.
    typedef struct { int p; int h; int e; } exp_t;
    exp_t exp_q[$];
    int   cyc = 0;
    int   m_last_rise = 0;
    int   m_last_fall = 0;
    logic m_prev  = 1'b0;
    logic m_armed = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!clr) begin
            m_prev  <= 1'b0;
            m_armed <= 1'b0;
            exp_q.delete();
        end else begin
            m_prev <= sig_in;
            if (sig_in && !m_prev) begin
                if (m_armed && ((cyc - m_last_rise) <= LIM))
                    exp_q.push_back('{cyc - m_last_rise, m_last_fall - m_last_rise, cyc});
                m_armed     <= 1'b1;
                m_last_rise <= cyc;
            end else if (!sig_in && m_prev) begin
                m_last_fall <= cyc;
            end
        end
    end

    // Output monitor: every meas_valid is checked against the model queue.
    int            pulse_cnt = 0;
    int            last_pulse_cyc = 0;
    int            last_gap = 0;
    logic [CW-1:0] last_period = '0;
    logic [CW-1:0] last_high = '0;
    logic          last_odd = 1'b0;
    logic          last_ovf = 1'b0;

    always @(negedge clk) begin
        if (meas_valid) begin
            pulse_cnt      <= pulse_cnt + 1;
            last_gap       <= cyc - last_pulse_cyc;
            last_pulse_cyc <= cyc;
            last_period    <= period;
            last_high      <= high_time;
            last_odd       <= is_odd;
            last_ovf       <= ovf;
            if (exp_q.size() == 0) begin
                check("model_pending", exp_q.size(), 1);
            end else begin
                check("model_period", period, exp_q[0].p);
                check("model_high", high_time, exp_q[0].h);
                check("model_odd", is_odd, exp_q[0].p % 2);
                check("model_latency", cyc - exp_q[0].e, LAT);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic hold(input logic v, input int n);
        sig_in = v;
        repeat (n) @(posedge clk);
        #5;
    endtask

    task automatic hold_r(input logic v, input int n);
        sig_in = v;
        repeat (n) @(posedge clk);
        #($urandom_range(1, 19));
    endtask

    task automatic do_reset(input bit chk);
        clr    = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #5;
        if (chk) begin
            check("rst_period", period, 0);
            check("rst_high", high_time, 0);
            check("rst_odd", is_odd, 0);
            check("rst_valid", meas_valid, 0);
            check("rst_ovf", ovf, 0);
        end
        clr = 1'b1;
        hold(1'b0, 4);
    endtask

    typedef struct {
        int hi; int lo; int reps;
        int per; int hgh; int odd; int pulses; int gap; int ovf_end;
    } vec_t;
    vec_t vt[9];

    initial begin
        int p0;
        int rk;
        int t_ovf;

        vt[0] = '{3,   4,   5, 7,   3,   1, 4, 7,  0};
        vt[1] = '{4,   4,   4, 8,   4,   0, 3, 8,  0};
        vt[2] = '{1,   1,   6, 2,   1,   0, 5, 2,  0};
        vt[3] = '{2,   3,   3, 5,   2,   1, 2, 5,  0};
        vt[4] = '{5,   1,   3, 6,   5,   0, 2, 6,  0};
        vt[5] = '{1,   2,   4, 3,   1,   1, 3, 3,  0};
        vt[6] = '{10,  7,   3, 17,  10,  1, 2, 17, 0};
        vt[7] = '{100, 155, 2, 255, 100, 1, 1, 0,  1};
        vt[8] = '{100, 156, 2, 0,   0,   0, 0, 0,  1};

        @(posedge clk);
        #5;
        do_reset(1'b1);

        for (int i = 0; i < 9; i++) begin
            do_reset(1'b0);
            p0 = pulse_cnt;
            for (int r = 0; r < vt[i].reps; r++) begin
                hold(1'b1, vt[i].hi);
                hold(1'b0, vt[i].lo);
            end
            hold(1'b0, 8);
            check($sformatf("v%0d_pulses", i), pulse_cnt - p0, vt[i].pulses);
            if (vt[i].pulses > 0) begin
                check($sformatf("v%0d_period", i), last_period, vt[i].per);
                check($sformatf("v%0d_high", i), last_high, vt[i].hgh);
                check($sformatf("v%0d_odd", i), last_odd, vt[i].odd);
                check($sformatf("v%0d_pulse_ovf", i), last_ovf, 0);
            end
            if (vt[i].pulses > 1) check($sformatf("v%0d_spacing", i), last_gap, vt[i].gap);
            check($sformatf("v%0d_ovf_end", i), ovf, vt[i].ovf_end);
        end

        // Timeout with sig_in stuck high, then recovery on two rises 9 apart.
        do_reset(1'b0);
        hold(1'b1, 4); hold(1'b0, 5); hold(1'b1, 4); hold(1'b0, 5);
        hold(1'b1, 2);
        rk = m_last_rise;
        t_ovf = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (ovf) begin
                t_ovf = cyc;
                break;
            end
        end
        check("ovf_delay", t_ovf - rk, 259);
        check("ovf_state", dut.state_r, SEEK);
        check("ovf_period_held", period, 9);
        check("ovf_high_held", high_time, 4);
        @(posedge clk);
        #5;
        hold(1'b1, 3);
        hold(1'b0, 6);
        p0 = pulse_cnt;
        hold(1'b1, 4); hold(1'b0, 5);
        check("ovf_rearm_pulses", pulse_cnt - p0, 0);
        check("ovf_sticky", ovf, 1);
        hold(1'b1, 4); hold(1'b0, 4);
        check("ovf_recover_pulses", pulse_cnt - p0, 1);
        check("ovf_recover_period", last_period, 9);
        check("ovf_recover_high", last_high, 4);
        check("ovf_recover_flag", last_ovf, 0);
        check("ovf_cleared", ovf, 0);

        // Reset asserted four cycles into a 7-cycle period.
        do_reset(1'b0);
        hold(1'b1, 3); hold(1'b0, 4); hold(1'b1, 3); hold(1'b0, 4);
        hold(1'b1, 3); hold(1'b0, 1);
        check("pre_rst_period", period, 7);
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #5;
        check("mid_rst_period", period, 0);
        check("mid_rst_high", high_time, 0);
        check("mid_rst_odd", is_odd, 0);
        check("mid_rst_valid", meas_valid, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_state", dut.state_r, SEEK);
        repeat (2) @(posedge clk);
        #5;
        clr = 1'b1;
        hold(1'b0, 3);
        p0 = pulse_cnt;
        hold(1'b1, 3); hold(1'b0, 4);
        check("rst_first_rise_pulses", pulse_cnt - p0, 0);
        hold(1'b1, 3); hold(1'b0, 4);
        check("rst_second_rise_pulses", pulse_cnt - p0, 1);
        check("rst_second_period", last_period, 7);
        check("rst_second_high", last_high, 3);

        // Random segment lengths with random sub-cycle edge placement.
        do_reset(1'b0);
        p0 = pulse_cnt;
        for (int s = 0; s < 40; s++) begin
            hold_r(1'b1, $urandom_range(1, 12));
            hold_r(1'b0, $urandom_range(1, 12));
        end
        hold(1'b0, 10);
        check("rand_pulses", pulse_cnt - p0, 39);
        check("model_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter CNT_W, default 16: width of the period and high-time counters and outputs.
REQ-002 Parameter SYNC_STAGES, default 2: number of flip-flop stages synchronising sig_in into the clk domain (legal range 2..4).
REQ-003 clk  input  1  the single system clock; every flop is clocked on its rising edge.
REQ-004 clr  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 sig_in  input  1  measured signal, asynchronous to clk (for example a divided clock).
REQ-006 period  output  CNT_W  clk cycles between the last two accepted rising edges of sig_in.
REQ-007 high_time  output  CNT_W  clk cycles sig_in was high within the last measured period.
REQ-008 is_odd  output  1  period[0] of the last measurement.
REQ-009 meas_valid  output  1  one-cycle pulse when period, high_time and is_odd update.
REQ-010 ovf  output  1  sticky timeout flag: no edge seen within 2^CNT_W-1 cycles.

Function
REQ-011 sig_in SHALL pass through SYNC_STAGES flops, then one more delay flop; rise = sync & ~dly and fall = ~sync & dly, each one cycle wide.
REQ-012 FSM states SHALL be SEEK (waiting for the first rise) and MEAS (counting); reset enters SEEK.
REQ-013 In SEEK, the first rise SHALL load cnt=1, set hi_seen=0, and enter MEAS, with no meas_valid.
REQ-014 In MEAS, cnt SHALL increment by 1 each cycle that has no rise.
REQ-015 In MEAS, a fall SHALL latch hi_cnt=cnt.
REQ-016 In MEAS, a rise SHALL register period=cnt and high_time=hi_cnt, set is_odd=cnt[0], pulse meas_valid high the next cycle, clear ovf, reload cnt=1, and stay in MEAS.
REQ-017 Measurement latency: meas_valid SHALL go high exactly 1 cycle after the cycle in which rise is true, and SYNC_STAGES+2 cycles after sig_in rises ahead of a clk edge.
REQ-018 Outputs SHALL hold their values between meas_valid pulses.
REQ-019 When cnt reaches 2^CNT_W-1 in MEAS without a rise, the block SHALL set ovf=1, enter SEEK, and leave period and high_time unchanged.
REQ-020 A rise in the same cycle that cnt reaches its limit SHALL be treated as a valid measurement (period=2^CNT_W-1), with no ovf.
REQ-021 If rise and the limit occur together with no fall seen, high_time SHALL be the last latched hi_cnt, which the rise path clears to 0 on reload.
REQ-022 The minimum measurable period SHALL be 2 (sig_in toggling every clk cycle), giving high_time=1.
REQ-023 A constant sig_in (high or low) SHALL produce no meas_valid, only ovf after timeout.

Reset
REQ-024 While clr=0: sync chain, dly, cnt, hi_cnt, period, high_time, is_odd, meas_valid and ovf SHALL all be 0, and the state SHALL be SEEK.
REQ-025 Reset release SHALL be synchronous to clk by board design; no internal reset synchroniser.
REQ-026 Reset asserted mid-measurement SHALL discard the partial count; the first rise after release SHALL only re-arm (REQ-013).

Structure
REQ-027 Package freq_meas_pkg SHALL hold the state enum (SEEK, MEAS) and the default CNT_W constant.
REQ-028 Sub-module sync_edge_det SHALL hold the synchroniser, delay flop and rise/fall outputs (parameter SYNC_STAGES, ports clk, clr).
REQ-029 The FSM, counters and output registers SHALL live in clk_period_meter; target size is about 150-250 lines of RTL in total.

Verification (clk period 20 ns, SYNC_STAGES=2, CNT_W=8 unless noted)
REQ-030 sig_in period 7 cycles, high 3, repeated 5 times -> after the first rise, 4 meas_valid pulses, each with period=7, high_time=3, is_odd=1.
REQ-031 sig_in period 8, high 4 -> period=8, high_time=4, is_odd=0; meas_valid 1 cycle wide with spacing 8.
REQ-032 sig_in toggling every cycle -> period=2, high_time=1, is_odd=0 every 2 cycles.
REQ-033 sig_in held high after one rise -> ovf=1 exactly 255 cycles after the rise-detect cycle, state SEEK; the next two rises 9 cycles apart -> meas_valid with period=9 and ovf=0.
REQ-034 clr pulsed low 4 cycles into a 7-cycle period -> all outputs 0 during reset; no meas_valid on the first rise after release; the second rise gives period=7.
REQ-035 The bench SHALL compare every meas_valid against a reference model counting synchronised edges, and SHALL include a run with sig_in edges placed at random sub-cycle offsets.
